// File: rtl/instr_sequencer.sv
// rtl/instr_sequencer.sv - multi-cycle instruction sequencer (IDLE/FETCH/EXEC/MEM/WB)
//
// Ports:
//   clk, rst_n            clock (rising edge), asynchronous active-low reset
//   run                   level: execute instructions back-to-back
//   step_req              rising edge requests one instruction while run=0
//   step_ack              one-cycle pulse in WB of a stepped instruction
//   ctl_RegWr/MemWr/MemToReg  control decoder outputs for the current instruction
//   pc_en                 one-cycle PC advance enable (WB)
//   reg_wr_en, mem_wr_en  gated register-file / data-memory write enables
//   phase                 current state (IDLE=0 FETCH=1 EXEC=2 MEM=3 WB=4)
//   inst_count            retired-instruction counter (wraps)
module instr_sequencer #(
   parameter int EXEC_WAIT = 2,
   parameter int MEM_WAIT  = 1,
   parameter int CNT_W     = 4
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        run,
   input  logic        step_req,
   output logic        step_ack,
   input  logic        ctl_RegWr,
   input  logic        ctl_MemWr,
   input  logic        ctl_MemToReg,
   output logic        pc_en,
   output logic        reg_wr_en,
   output logic        mem_wr_en,
   output logic [2:0]  phase,
   output logic [31:0] inst_count
);

   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_FETCH = 3'd1;
   localparam logic [2:0] S_EXEC  = 3'd2;
   localparam logic [2:0] S_MEM   = 3'd3;
   localparam logic [2:0] S_WB    = 3'd4;

   localparam logic [CNT_W-1:0] EXEC_LOAD = CNT_W'(EXEC_WAIT);
   localparam logic [CNT_W-1:0] MEM_LOAD  = CNT_W'(MEM_WAIT);
   localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

   logic [2:0]       state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             stepping_q, stepping_d;
   logic             step_pending_q, step_pending_d;
   logic             step_req_d;
   logic             step_consume;
   logic             step_rise;
   logic [31:0]      inst_count_q;

   assign step_rise = step_req & ~step_req_d;

   // An edge arriving in the same cycle a pending step is consumed is kept,
   // so no request is ever dropped.
   assign step_pending_d = (step_pending_q & ~step_consume) | step_rise;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q        <= S_IDLE;
         cnt_q          <= '0;
         stepping_q     <= 1'b0;
         step_pending_q <= 1'b0;
         step_req_d     <= 1'b0;
         inst_count_q   <= '0;
      end else begin
         state_q        <= state_d;
         cnt_q          <= cnt_d;
         stepping_q     <= stepping_d;
         step_pending_q <= step_pending_d;
         step_req_d     <= step_req;
         if (state_q == S_WB) begin
            inst_count_q <= inst_count_q + 32'd1;
         end
      end
   end

   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      stepping_d   = stepping_q;
      step_consume = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (run) begin
               state_d    = S_FETCH;
               stepping_d = 1'b0;
            end else if (step_pending_q) begin
               state_d      = S_FETCH;
               stepping_d   = 1'b1;
               step_consume = 1'b1;
            end
         end
         S_FETCH: begin
            state_d = S_EXEC;
            cnt_d   = EXEC_LOAD;
         end
         S_EXEC: begin
            if (cnt_q != '0) begin
               cnt_d = cnt_q - CNT_ONE;
            end else if (ctl_MemWr | ctl_MemToReg) begin
               state_d = S_MEM;
               cnt_d   = MEM_LOAD;
            end else begin
               state_d = S_WB;
            end
         end
         S_MEM: begin
            if (cnt_q != '0) begin
               cnt_d = cnt_q - CNT_ONE;
            end else begin
               state_d = S_WB;
            end
         end
         S_WB: begin
            // A stepped instruction always parks in IDLE, even if run rose meanwhile.
            state_d = (run && !stepping_q) ? S_FETCH : S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_comb begin
      pc_en     = 1'b0;
      reg_wr_en = 1'b0;
      mem_wr_en = 1'b0;
      step_ack  = 1'b0;
      case (state_q)
         S_MEM: begin
            mem_wr_en = ctl_MemWr & (cnt_q == '0);
         end
         S_WB: begin
            pc_en     = 1'b1;
            reg_wr_en = ctl_RegWr;
            step_ack  = stepping_q;
         end
         default: begin
         end
      endcase
   end

   assign phase      = state_q;
   assign inst_count = inst_count_q;

endmodule

// File: tb/tb_instr_sequencer.sv
// tb/tb_instr_sequencer.sv - randomized model-checked bench for instr_sequencer
module tb_instr_sequencer;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst_n;
   logic        run_i      [2];
   logic        step_i     [2];
   logic        regwr_i    [2];
   logic        memwr_i    [2];
   logic        memtoreg_i [2];
   logic        step_ack_w [2];
   logic        pc_en_w    [2];
   logic        reg_wr_w   [2];
   logic        mem_wr_w   [2];
   logic [2:0]  phase_w    [2];
   logic [31:0] cnt_w      [2];

   instr_sequencer dut (
      .clk(clk), .rst_n(rst_n), .run(run_i[0]), .step_req(step_i[0]),
      .step_ack(step_ack_w[0]), .ctl_RegWr(regwr_i[0]), .ctl_MemWr(memwr_i[0]),
      .ctl_MemToReg(memtoreg_i[0]), .pc_en(pc_en_w[0]), .reg_wr_en(reg_wr_w[0]),
      .mem_wr_en(mem_wr_w[0]), .phase(phase_w[0]), .inst_count(cnt_w[0])
   );

   instr_sequencer #(.EXEC_WAIT(0), .MEM_WAIT(0), .CNT_W(4)) dut_z (
      .clk(clk), .rst_n(rst_n), .run(run_i[1]), .step_req(step_i[1]),
      .step_ack(step_ack_w[1]), .ctl_RegWr(regwr_i[1]), .ctl_MemWr(memwr_i[1]),
      .ctl_MemToReg(memtoreg_i[1]), .pc_en(pc_en_w[1]), .reg_wr_en(reg_wr_w[1]),
      .mem_wr_en(mem_wr_w[1]), .phase(phase_w[1]), .inst_count(cnt_w[1])
   );

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
      end
   endtask

   // Reference model: an instruction is a span of lat() cycles indexed by m_t;
   // FETCH is cycle 0, WB is the last, EXEC and MEM fill the middle.
   int          ew [2] = '{2, 0};
   int          mw [2] = '{1, 0};
   bit          m_busy [2];
   bit          m_stepping [2];
   bit          m_pend [2];
   bit          m_sreq_d [2];
   int          m_t [2];
   logic [31:0] m_cnt [2];

   function automatic int lat(int i);
      return 3 + ew[i] + ((memwr_i[i] | memtoreg_i[i]) ? mw[i] + 1 : 0);
   endfunction

   function automatic bit in_wb(int i);
      return m_busy[i] && (m_t[i] == lat(i) - 1);
   endfunction

   function automatic int exp_phase(int i);
      if (!m_busy[i]) return 0;
      if (m_t[i] == 0) return 1;
      if (m_t[i] <= ew[i] + 1) return 2;
      if (in_wb(i)) return 4;
      return 3;
   endfunction

   task automatic model_reset();
      for (int i = 0; i < 2; i++) begin
         m_busy[i] = 0; m_stepping[i] = 0; m_pend[i] = 0; m_sreq_d[i] = 0;
         m_t[i] = 0; m_cnt[i] = '0;
      end
   endtask

   task automatic model_step(input int i);
      bit rise;
      rise = step_i[i] & ~m_sreq_d[i];
      m_sreq_d[i] = step_i[i];
      if (!m_busy[i]) begin
         if (run_i[i]) begin
            m_busy[i] = 1; m_t[i] = 0; m_stepping[i] = 0;
         end else if (m_pend[i]) begin
            m_busy[i] = 1; m_t[i] = 0; m_stepping[i] = 1; m_pend[i] = 0;
         end
      end else if (in_wb(i)) begin
         m_cnt[i] = m_cnt[i] + 32'd1;
         if (run_i[i] && !m_stepping[i]) m_t[i] = 0;
         else m_busy[i] = 0;
      end else begin
         m_t[i]++;
      end
      if (rise) m_pend[i] = 1;
   endtask

   task automatic check_all();
      for (int i = 0; i < 2; i++) begin
         check_eq($sformatf("phase[%0d]", i), 32'(phase_w[i]), 32'(exp_phase(i)));
         check_eq($sformatf("pc_en[%0d]", i), 32'(pc_en_w[i]), 32'(in_wb(i)));
         check_eq($sformatf("reg_wr_en[%0d]", i), 32'(reg_wr_w[i]), 32'(in_wb(i) && regwr_i[i]));
         check_eq($sformatf("mem_wr_en[%0d]", i), 32'(mem_wr_w[i]),
                  32'(m_busy[i] && memwr_i[i] && (m_t[i] == lat(i) - 2)));
         check_eq($sformatf("step_ack[%0d]", i), 32'(step_ack_w[i]), 32'(in_wb(i) && m_stepping[i]));
         check_eq($sformatf("inst_count[%0d]", i), cnt_w[i], m_cnt[i]);
      end
   endtask

   task automatic cycle();
      @(posedge clk);
      for (int i = 0; i < 2; i++) begin
         if (!rst_n) model_reset();
         else model_step(i);
      end
      @(negedge clk);
      check_all();
   endtask

   task automatic set_ctl(input logic r, input logic w, input logic m);
      for (int i = 0; i < 2; i++) begin
         regwr_i[i] = r; memwr_i[i] = w; memtoreg_i[i] = m;
      end
   endtask

   task automatic set_run(input logic v);
      run_i[0] = v; run_i[1] = v;
   endtask

   task automatic set_step(input logic v);
      step_i[0] = v; step_i[1] = v;
   endtask

   task automatic wait_idle();
      int n;
      n = 0;
      while ((m_busy[0] || m_busy[1]) && n < 60) begin
         cycle();
         n++;
      end
      check_eq("idle_timeout", 32'(n >= 60), 32'd0);
   endtask

   logic [31:0] base;

   initial begin
      rst_n = 1'b0;
      set_run(0); set_step(0); set_ctl(0, 0, 0);
      model_reset();
      #2;
      check_all();
      cycle(); cycle();
      rst_n = 1'b1;

      // add, free-running
      set_ctl(1, 0, 0); set_run(1);
      repeat (12) cycle();
      set_run(0); wait_idle();

      // lw then sw, one instruction each
      set_ctl(1, 0, 1); set_run(1); cycle(); set_run(0); wait_idle();
      set_ctl(0, 1, 0); set_run(1); cycle(); set_run(0); wait_idle();

      // single-step pulse, then step held high
      set_ctl(1, 0, 0);
      set_step(1); cycle(); set_step(0); wait_idle();
      base = cnt_w[0];
      set_step(1); repeat (20) cycle(); set_step(0); wait_idle();
      check_eq("step_held_once", cnt_w[0], base + 32'd1);

      // three edges during a stepped instruction -> two instructions
      base = cnt_w[0];
      set_step(1); cycle(); set_step(0); cycle();
      set_step(1); cycle(); set_step(0); cycle();
      set_step(1); cycle(); set_step(0);
      repeat (30) cycle();
      check_eq("step_merge", cnt_w[0], base + 32'd2);

      // reset during EXEC
      set_run(1);
      repeat (3) cycle();
      #1 rst_n = 1'b0;
      #1 model_reset();
      check_all();
      cycle(); cycle();
      rst_n = 1'b1;
      repeat (6) cycle();
      set_run(0); wait_idle();

      // counter wrap
      force dut.inst_count_q = 32'hFFFF_FFFF;
      #1 release dut.inst_count_q;
      m_cnt[0] = 32'hFFFF_FFFF;
      set_run(1); cycle(); set_run(0); wait_idle();
      check_eq("wrap", cnt_w[0], 32'd0);

      // randomized traffic
      repeat (4000) begin
         for (int i = 0; i < 2; i++) begin
            if ($urandom_range(15) == 0) run_i[i] = ~run_i[i];
            if ($urandom_range(3) == 0) step_i[i] = ~step_i[i];
            if ((!m_busy[i] || m_t[i] == 0) && $urandom_range(1) == 1) begin
               regwr_i[i]    = 1'($urandom_range(1));
               memwr_i[i]    = 1'($urandom_range(1));
               memtoreg_i[i] = 1'($urandom_range(1));
            end
         end
         cycle();
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
